// File: rtl/tlc_pkg.sv
// tlc_pkg: shared types for the timed traffic-light controller.
//   lamp_t  : 2-bit lamp-head code driven to the highway and country encoders
//   state_t : controller phase, 3-bit encoding (FL only reachable when the
//             TLC_FLASH_EN macro is defined in the controller build)
package tlc_pkg;

  localparam int LAMP_W  = 2;
  localparam int STATE_W = 3;

  typedef enum logic [LAMP_W-1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10,
    OFF    = 2'b11
  } lamp_t;

  typedef enum logic [STATE_W-1:0] {
    HG  = 3'd0,  // highway green
    HY  = 3'd1,  // highway yellow
    AR1 = 3'd2,  // all-red before country green
    CG  = 3'd3,  // country green
    CY  = 3'd4,  // country yellow
    AR2 = 3'd5,  // all-red before highway green
    FL  = 3'd6   // maintenance flash
  } state_t;

endpackage

// File: rtl/tlc_timer.sv
// tlc_timer: loadable down-counter that times one controller phase.
//   clock      in  sole clock
//   clear      in  synchronous active-high reset, count := RESET_VALUE
//   load       in  synchronous load of load_value (ignored while clear=1)
//   load_value in  CNT_W-bit value to load (phase duration minus one)
//   expired    out high while the count is zero
// The count saturates at zero, so a phase that is waiting on an input
// (highway green with no car) simply stays expired.
module tlc_timer #(
  parameter int unsigned       CNT_W       = 8,
  parameter logic [CNT_W-1:0]  RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             expired
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clock) begin
    if (clear) begin
      count_reg <= RESET_VALUE;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/tlc_timed_ctrl.sv
// tlc_timed_ctrl: highway/country-road traffic-light controller with
// parameterised phase durations timed by a single down-counter.
//   clock  in  sole clock, all state changes on posedge
//   clear  in  synchronous active-high reset (forces highway green)
//   X      in  car present on the country road
//   flash  in  maintenance flash request (only with TLC_FLASH_EN)
//   hwy    out registered highway lamp code (lamp_t encoding)
//   cntry  out registered country lamp code (lamp_t encoding)
// Optional feature macro: TLC_FLASH_EN adds the flash port and the FL state.
// Lamps are decoded from the next state and registered alongside the state,
// so they change on the same edge as the phase.
module tlc_timed_ctrl
  import tlc_pkg::*;
#(
  parameter int unsigned YELLOW_CYCLES    = 3,
  parameter int unsigned ALLRED_CYCLES    = 2,
  parameter int unsigned MIN_GREEN_CYCLES = 4,
  parameter int unsigned MAX_CNTRY_CYCLES = 8,
  parameter int unsigned FLASH_CYCLES     = 2,
  parameter int unsigned CNT_W            = 8
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        X,
`ifdef TLC_FLASH_EN
  input  logic        flash,
`endif
  output logic [1:0]  hwy,
  output logic [1:0]  cntry
);

  // Timer reload values: a phase of D cycles starts its count at D-1 and
  // may leave on the edge that follows the count reaching zero.
  localparam logic [CNT_W-1:0] YELLOW_LOAD    = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALLRED_LOAD    = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_GREEN_LOAD = CNT_W'(MIN_GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_CNTRY_LOAD = CNT_W'(MAX_CNTRY_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD     = CNT_W'(FLASH_CYCLES - 1);

  state_t           state_reg, state_next;
  lamp_t            hwy_reg, hwy_next;
  lamp_t            cntry_reg, cntry_next;
  logic             timer_load;
  logic [CNT_W-1:0] timer_value;
  logic             timer_expired;

`ifdef TLC_FLASH_EN
  // blink_reg=0 shows YELLOW/RED, 1 shows OFF/OFF while flashing.
  logic             blink_reg, blink_next;
  logic             blink_reload;
`endif

  // -------------------------------------------------------------------
  // Phase timer. Reset value matches the highway minimum green so that
  // clear lands in HG with a fresh minimum-green count.
  // -------------------------------------------------------------------
  tlc_timer #(
    .CNT_W       (CNT_W),
    .RESET_VALUE (MIN_GREEN_LOAD)
  ) u_timer (
    .clock      (clock),
    .clear      (clear),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (timer_expired)
  );

  // -------------------------------------------------------------------
  // State, lamp (and blink) registers.
  // -------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (clear) begin
      state_reg <= HG;
      hwy_reg   <= GREEN;
      cntry_reg <= RED;
`ifdef TLC_FLASH_EN
      blink_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      hwy_reg   <= hwy_next;
      cntry_reg <= cntry_next;
`ifdef TLC_FLASH_EN
      blink_reg <= blink_next;
`endif
    end
  end

  // -------------------------------------------------------------------
  // Next-state logic.
  // -------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
`ifdef TLC_FLASH_EN
    blink_next   = blink_reg;
    blink_reload = 1'b0;
`endif
    case (state_reg)
      HG:  if (timer_expired && X) state_next = HY;
      HY:  if (timer_expired)      state_next = AR1;
      AR1: if (timer_expired)      state_next = CG;
      // Country green ends as soon as the road empties, or on the
      // maximum-green timeout even with cars still waiting.
      CG:  if (!X || timer_expired) state_next = CY;
      CY:  if (timer_expired)      state_next = AR2;
      AR2: if (timer_expired)      state_next = HG;
`ifdef TLC_FLASH_EN
      FL: begin
        // Blink half-period is timed by the same counter, reloaded in place.
        if (timer_expired) begin
          blink_next   = ~blink_reg;
          blink_reload = 1'b1;
        end
      end
`endif
      default: state_next = HG;  // unused encodings recover to HG
    endcase

`ifdef TLC_FLASH_EN
    // Flash request overrides the normal sequence from any phase; leaving
    // flash always passes through a full all-red clearance.
    if (flash) begin
      if (state_reg != FL) begin
        state_next   = FL;
        blink_next   = 1'b0;
        blink_reload = 1'b0;
      end
    end else if (state_reg == FL) begin
      state_next   = AR2;
      blink_reload = 1'b0;
    end
`endif
  end

  // -------------------------------------------------------------------
  // Timer reload: on every phase change, with the duration of the phase
  // being entered.
  // -------------------------------------------------------------------
  always_comb begin
    timer_value = MIN_GREEN_LOAD;
    case (state_next)
      HG:      timer_value = MIN_GREEN_LOAD;
      HY, CY:  timer_value = YELLOW_LOAD;
      AR1, AR2: timer_value = ALLRED_LOAD;
      CG:      timer_value = MAX_CNTRY_LOAD;
      FL:      timer_value = FLASH_LOAD;
      default: timer_value = MIN_GREEN_LOAD;
    endcase
  end

`ifdef TLC_FLASH_EN
  assign timer_load = (state_next != state_reg) || blink_reload;
`else
  assign timer_load = (state_next != state_reg);
`endif

  // -------------------------------------------------------------------
  // Lamp decode from the next state so lamps register with the state.
  // -------------------------------------------------------------------
  always_comb begin
    hwy_next   = GREEN;
    cntry_next = RED;
    case (state_next)
      HG: begin
        hwy_next   = GREEN;
        cntry_next = RED;
      end
      HY: begin
        hwy_next   = YELLOW;
        cntry_next = RED;
      end
      AR1, AR2: begin
        hwy_next   = RED;
        cntry_next = RED;
      end
      CG: begin
        hwy_next   = RED;
        cntry_next = GREEN;
      end
      CY: begin
        hwy_next   = RED;
        cntry_next = YELLOW;
      end
`ifdef TLC_FLASH_EN
      FL: begin
        if (blink_next) begin
          hwy_next   = OFF;
          cntry_next = OFF;
        end else begin
          hwy_next   = YELLOW;
          cntry_next = RED;
        end
      end
`endif
      default: begin
        hwy_next   = GREEN;
        cntry_next = RED;
      end
    endcase
  end

  assign hwy   = hwy_reg;
  assign cntry = cntry_reg;

endmodule

// File: doc/tlc_timed_ctrl.md
# tlc_timed_ctrl

Parametrised highway/country-road traffic-light controller that supersedes the fixed-delay five-state controller. Phase durations are set by parameters and timed with an explicit down-counter, so no clock-edge waits occur inside combinational logic. It adds a highway minimum-green guarantee, a country-road maximum-green timeout, and a symmetric all-red clearance after the country phase. The block drives the two lamp-head encoders directly from registered outputs.

## Interface
- YELLOW_CYCLES, 3, yellow duration in clocks (≥1)
- ALLRED_CYCLES, 2, all-red clearance duration in clocks (≥1)
- MIN_GREEN_CYCLES, 4, minimum highway green in clocks (≥1)
- MAX_CNTRY_CYCLES, 8, maximum country green in clocks (≥1)
- FLASH_CYCLES, 2, half-period of flash blink in clocks (≥1); used only with TLC_FLASH_EN
- CNT_W, 8, timer width; must hold max(parameters)−1
- clock  in  1  sole clock, all state changes on posedge
- clear  in  1  synchronous, active-high reset
- X  in  1  car present on country road, sampled on each posedge
- flash  in  1  maintenance flash request; present only with TLC_FLASH_EN
- hwy  out  2  highway lamp: RED=00, YELLOW=01, GREEN=10, OFF=11
- cntry  out  2  country lamp, same encoding

## Operation
- States and lamps (hwy/cntry):
  - HG: GREEN/RED
  - HY: YELLOW/RED
  - AR1: RED/RED
  - CG: RED/GREEN
  - CY: RED/YELLOW
  - AR2: RED/RED
  - FL: flash, only with the macro
- Timer: loaded with D−1 on entry to a state of duration D; decrements each cycle; saturates at 0. "Expired" means timer==0.
- Transitions:
  - HG→HY when expired and X=1. HG is held indefinitely while X=0.
  - HY→AR1 when expired (YELLOW_CYCLES).
  - AR1→CG when expired (ALLRED_CYCLES).
  - CG→CY when X=0, or when expired (MAX_CNTRY_CYCLES) even if X=1.
  - CY→AR2 when expired (YELLOW_CYCLES).
  - AR2→HG when expired (ALLRED_CYCLES). HG reloads MIN_GREEN_CYCLES−1.
- The minimum-green count always runs from HG entry. X rising late in HG therefore transitions on the next edge if the minimum green has already elapsed.
- X glitches during HY, AR1, CY and AR2 are ignored; those phases always run their full duration.
- No state ever shows GREEN or YELLOW on both roads at once.

## Timing
- Moore outputs, registered. Lamps update on the same posedge as the state register.
- Reset:
  - clear=1 at a posedge forces state HG, hwy=GREEN, cntry=RED, timer=MIN_GREEN_CYCLES−1, on that edge.
  - clear has priority over every other input.
  - Mid-phase reset abandons the phase immediately, with no yellow or all-red sequence.
- Each timed state is occupied exactly D cycles.
- HG with X held high from reset release lasts exactly MIN_GREEN_CYCLES cycles.
- CG with X=0 on its first cycle lasts exactly 1 cycle.
- Country-road cycle latency with X steady high and default parameters:
  - HG 4, HY 3, AR1 2, CG 8, CY 3, AR2 2.
  - Total 22 cycles, then the sequence repeats while X=1.
- Undefined state encodings recover to HG on the next edge.

## Configuration
- TLC_FLASH_EN defined:
  - Adds the `flash` port and state FL.
  - flash=1 at any posedge (clear=0) enters FL on that edge from any state.
  - In FL, lamps alternate every FLASH_CYCLES cycles between hwy=YELLOW/cntry=RED and OFF/OFF, starting with YELLOW/RED.
  - flash=0 in FL enters AR2, which runs the full ALLRED_CYCLES, then HG.
- TLC_FLASH_EN undefined: no flash port, no FL state, and the encoding OFF is never driven.

## Structure
- Package tlc_pkg holds:
  - lamp encodings RED, YELLOW, GREEN, OFF
  - the state enum HG, HY, AR1, CG, CY, AR2, FL (3 bits)
- Sub-module tlc_timer: CNT_W-bit loadable down-counter with synchronous load, saturation at 0, and an `expired` flag. It is instantiated once and loaded on every state change.

## Test plan
- Reset and idle:
  - Stimulus: clear=1 for 2 cycles, then X=0 for 50 cycles.
  - Response: hwy=GREEN, cntry=RED throughout; never leaves HG.
- Full cycle, defaults:
  - Stimulus: X=1 steady from reset release.
  - Response: phase lengths HG 4, HY 3, AR1 2, CG 8 (max timeout), CY 3, AR2 2; repeats with a 22-cycle period.
- Early country release:
  - Stimulus: X=1 until the 3rd cycle of CG, then X=0.
  - Response: CG lasts 3 cycles, then CY 3 and AR2 2, then HG.
- Late request in HG:
  - Stimulus: X=0 for 10 cycles after reset, then X=1.
  - Response: HY entered on the first edge X=1 is sampled.
- Reset mid-phase:
  - Stimulus: clear=1 on the 2nd cycle of CY.
  - Response: next cycle shows hwy=GREEN, cntry=RED, and a fresh 4-cycle minimum green.
- Flash (TLC_FLASH_EN):
  - Stimulus: flash=1 during CG for 8 cycles.
  - Response: YELLOW/RED and OFF/OFF alternate every 2 cycles. After flash drops, RED/RED for 2 cycles, then GREEN/RED.
